// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - interval timer register map, control words and sequencer state encoding
package timer_regs_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

  localparam int CTL_ITO_BIT   = 0;
  localparam int CTL_CONT_BIT  = 1;
  localparam int CTL_START_BIT = 2;
  localparam int CTL_STOP_BIT  = 3;

  localparam logic [15:0] CTL_HALT_WORD = 16'(1 << CTL_STOP_BIT);
  localparam logic [15:0] CTL_ARM_WORD  = 16'((1 << CTL_START_BIT) | (1 << CTL_ITO_BIT));

  typedef enum logic [3:0] {
    S_IDLE,
    S_HALT,
    S_LOAD_L,
    S_LOAD_H,
    S_CLR,
    S_ARM,
    S_WAIT,
    S_ACK,
    S_HALT_ABORT
  } seq_state_e;

  // The timer never raises TO on a zero reload, so a zero period would hang the sequence.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/timer_step_sequencer_step_table.sv
// rtl/timer_step_sequencer_step_table.sv - period table: one write port, one asynchronous read port
module step_table #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/timer_step_sequencer.sv
// rtl/timer_step_sequencer.sv - steps a period table through the interval timer, one-shot per entry
module timer_step_sequencer
  import timer_regs_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic [IDX_W:0]   seq_len,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic             tmr_irq,
  output logic             step_pulse,
  output logic [IDX_W-1:0] step_index,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

  seq_state_e       state, state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   len;
  logic             loop_r;
  logic [31:0]      period_r;
  logic [31:0]      tbl_rdata;
  logic [31:0]      period_now;
  logic             accept;
  logic             last_step;

  step_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_step_table (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx),
    .rdata (tbl_rdata)
  );

  assign accept     = start && !stop && (seq_len != '0) && (seq_len <= DEPTH_W);
  assign last_step  = ({1'b0, idx} == (len - 1'b1));
  // Both halves come from one snapshot so a table write mid-run cannot tear the period.
  assign period_now = (state == S_LOAD_L) ? clamp_period(tbl_rdata) : period_r;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (accept) state_next = S_HALT;
      S_HALT:       state_next = S_LOAD_L;
      S_LOAD_L:     state_next = S_LOAD_H;
      S_LOAD_H:     state_next = S_CLR;
      S_CLR:        state_next = S_ARM;
      S_ARM:        state_next = S_WAIT;
      S_WAIT:       if (tmr_irq) state_next = S_ACK;
      S_ACK:        state_next = (last_step && !loop_r) ? S_IDLE : S_LOAD_L;
      S_HALT_ABORT: state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    if (stop && state != S_IDLE) begin
      state_next = S_HALT_ABORT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      len      <= '0;
      loop_r   <= 1'b0;
      period_r <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        idx    <= '0;
        len    <= seq_len;
        loop_r <= loop_en;
      end
      if (state == S_LOAD_L) begin
        period_r <= period_now;
      end
      if (state == S_ACK && state_next == S_LOAD_L) begin
        idx <= last_step ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    step_pulse     = 1'b0;
    done           = 1'b0;
    case (state)
      S_HALT, S_HALT_ABORT: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_CONTROL;
        tmr_writedata  = CTL_HALT_WORD;
      end
      S_LOAD_L: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_PERIOD_L;
        tmr_writedata  = period_now[15:0];
      end
      S_LOAD_H: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_PERIOD_H;
        tmr_writedata  = period_r[31:16];
      end
      S_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_STATUS;
      end
      S_ARM: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_CONTROL;
        tmr_writedata  = CTL_ARM_WORD;
      end
      S_ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_ADDR_STATUS;
        step_pulse     = 1'b1;
        done           = last_step && !loop_r;
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign step_index = idx;

endmodule

// File: tb/tb_timer_step_sequencer.sv
// tb/tb_timer_step_sequencer.sv - randomized self-checking bench with interval timer load model
module tb_timer_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [4:0]  seq_len = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic        step_pulse;
  logic [3:0]  step_index;
  logic        busy;
  logic        done;

  timer_step_sequencer #(.DEPTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .seq_len        (seq_len),
    .loop_en        (loop_en),
    .start          (start),
    .stop           (stop),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq),
    .step_pulse     (step_pulse),
    .step_index     (step_index),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer slave: TO sets on the tick where the count would pass 1; a zero count never fires.
  logic [15:0] t_pl, t_ph;
  logic [31:0] t_cnt;
  logic        t_to, t_ito, t_cont, t_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_pl <= '0; t_ph <= '0; t_cnt <= '0;
      t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0; t_run <= 1'b0;
    end else if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito  <= tmr_writedata[0];
          t_cont <= tmr_writedata[1];
          if (tmr_writedata[3]) t_run <= 1'b0;
          else if (tmr_writedata[2]) begin
            t_run <= 1'b1;
            t_cnt <= {t_ph, t_pl};
          end
        end
        3'd2: t_pl <= tmr_writedata;
        3'd3: t_ph <= tmr_writedata;
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 32'd1) begin
        t_to <= 1'b1;
        if (t_cont) t_cnt <= {t_ph, t_pl};
        else t_run <= 1'b0;
      end else if (t_cnt != 32'd0) begin
        t_cnt <= t_cnt - 32'd1;
      end
    end
  end

  assign tmr_irq = t_to & t_ito;

  int          pq_t[$];
  int          pq_i[$];
  int          pq_d[$];
  logic [18:0] wq[$];
  int          stray_done = 0;
  bit          busy_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (step_pulse) begin
        pq_t.push_back(cyc);
        pq_i.push_back(int'(step_index));
        pq_d.push_back(int'(done));
      end
      if (done && !step_pulse) stray_done++;
      if (tmr_chipselect && !tmr_write_n) wq.push_back({tmr_address, tmr_writedata});
      if (busy) busy_seen = 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] tbl [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    pq_t.delete(); pq_i.delete(); pq_d.delete(); wq.delete();
    busy_seen = 0;
  endtask

  task automatic load_table(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = tbl[i];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int len, input bit lp, input bit with_stop, output int c);
    seq_len = 5'(len); loop_en = lp; start = 1'b1; stop = with_stop;
    c = cyc;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  // Pulse k lands P(first)+7 cycles after the start cycle, then P(next)+6 apart; each step is four writes plus the ack.
  task automatic run_check(input int len, input string tag);
    int c, t, n;
    logic [31:0] p;
    int et[$];
    logic [18:0] ew[$];
    clear_obs();
    do_start(len, 1'b0, 1'b0, c);
    t = c;
    ew.push_back({3'd1, 16'h0008});
    for (int k = 0; k < len; k++) begin
      p = (tbl[k] == 32'd0) ? 32'd1 : tbl[k];
      t = t + int'(p) + ((k == 0) ? 7 : 6);
      et.push_back(t);
      ew.push_back({3'd2, p[15:0]});
      ew.push_back({3'd3, p[31:16]});
      ew.push_back({3'd0, 16'h0000});
      ew.push_back({3'd1, 16'h0005});
      ew.push_back({3'd0, 16'h0000});
    end
    wait_idle(t - c + 20, {tag, "_idle"});
    chk({tag, "_npulse"}, pq_t.size(), len);
    n = (pq_t.size() < len) ? pq_t.size() : len;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_ptime"}, pq_t[k], et[k]);
      chk({tag, "_pidx"}, pq_i[k], k);
      chk({tag, "_pdone"}, pq_d[k], (k == len - 1) ? 1 : 0);
    end
    chk({tag, "_nwrites"}, wq.size(), ew.size());
    n = (wq.size() < ew.size()) ? wq.size() : ew.size();
    for (int k = 0; k < n; k++) chk({tag, "_write"}, wq[k], ew[k]);
    chk({tag, "_timer_run"}, t_run, 0);
  endtask

  initial begin
    int c, n, k, len;
    int lt[4];
    logic [18:0] ew5[6];

    tick(3);
    chk("rst_cs", tmr_chipselect, 0);
    chk("rst_wn", tmr_write_n, 1);
    chk("rst_addr", tmr_address, 0);
    chk("rst_wdata", tmr_writedata, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_index", step_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick(2);

    tbl[0] = 10; tbl[1] = 20; tbl[2] = 30;
    load_table(3);
    run_check(3, "t1");

    tbl[0] = 32'h0001_0000;
    load_table(1);
    run_check(1, "t2");

    tbl[0] = 0;
    load_table(1);
    run_check(1, "t3");

    tbl[0] = 5; tbl[1] = 7;
    load_table(2);
    clear_obs();
    do_start(2, 1'b1, 1'b0, c);
    n = 0; k = 0;
    while (n < 4 && k < 200) begin
      @(negedge clk);
      k++;
      if (step_pulse) n++;
    end
    chk("t4_seen", n, 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(20, "t4_idle");
    lt[0] = c + 12; lt[1] = lt[0] + 13; lt[2] = lt[1] + 11; lt[3] = lt[2] + 13;
    chk("t4_npulse", pq_t.size(), 4);
    for (int i = 0; i < 4 && i < pq_t.size(); i++) begin
      chk("t4_ptime", pq_t[i], lt[i]);
      chk("t4_pidx", pq_i[i], i % 2);
      chk("t4_pdone", pq_d[i], 0);
    end
    chk("t4_timer_run", t_run, 0);

    tbl[0] = 30;
    load_table(1);
    clear_obs();
    do_start(1, 1'b0, 1'b0, c);
    tick(15);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(20, "t5_idle");
    ew5[0] = {3'd1, 16'h0008}; ew5[1] = {3'd2, 16'd30}; ew5[2] = {3'd3, 16'd0};
    ew5[3] = {3'd0, 16'd0};    ew5[4] = {3'd1, 16'h0005}; ew5[5] = {3'd1, 16'h0008};
    chk("t5_npulse", pq_t.size(), 0);
    chk("t5_nwrites", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk("t5_write", wq[i], ew5[i]);
    chk("t5_timer_run", t_run, 0);
    tbl[0] = 4;
    load_table(1);
    run_check(1, "t5_restart");

    clear_obs();
    do_start(0, 1'b0, 1'b0, c);
    tick(8);
    do_start(1, 1'b0, 1'b1, c);
    tick(8);
    do_start(17, 1'b0, 1'b0, c);
    tick(8);
    chk("t6_writes", wq.size(), 0);
    chk("t6_busy_seen", busy_seen, 0);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) tbl[i] = $urandom_range(0, 25);
      load_table(len);
      run_check(len, "rnd");
    end

    tbl[0] = 30;
    load_table(1);
    do_start(1, 1'b0, 1'b0, c);
    tick(10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cs", tmr_chipselect, 0);
    chk("mid_rst_wn", tmr_write_n, 1);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    chk("stray_done", stray_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
